// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
// The slave side is the adder; the master side is the producer plus consumer.
interface add_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, y, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, y, cout, ovf
    );
endinterface

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor; the carry ripples one WIDTH/STAGES slice per clock.
// Optional: define ADD_PIPE_SAT_EN to saturate y to the signed bound on overflow.
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic       clk,
    input logic       rst,
    add_pipe_if.slave bus
);
    localparam int S = WIDTH / STAGES;

    logic             vld_q   [STAGES];
    logic             vld_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];

    logic [WIDTH-1:0] y_q, y_d, y_n;
    logic             cout_q, cout_d, cout_n;
    logic             ovf_q, ovf_d, ovf_n;

    logic             rdy  [STAGES+1];
    logic             load [STAGES];
    logic             v_in [STAGES];
    logic             c_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic [WIDTH-1:0] nsum [STAGES];
    logic [S:0]       slc  [STAGES];

`ifdef ADD_PIPE_SAT_EN
    function automatic logic signed [WIDTH-1:0] sat_fn(
        input logic signed [WIDTH-1:0] sum,
        input logic                    ovf,
        input logic                    neg_dir
    );
        logic signed [WIDTH-1:0] lim;
        lim = neg_dir ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return ovf ? lim : sum;
    endfunction
`endif

    always_comb begin
        // A stage can take a beat if it is empty or if anything above it can drain.
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld_q[k] || rdy[k+1];
        end

        a_in[0] = bus.a;
        b_in[0] = bus.b ^ {WIDTH{bus.sub}};
        c_in[0] = bus.sub;
        s_in[0] = '0;
        v_in[0] = bus.in_valid && !rst;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = carry_q[k-1];
            s_in[k] = sum_q[k-1];
            v_in[k] = vld_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            load[k]  = v_in[k] && rdy[k];
            vld_d[k] = load[k] || (vld_q[k] && !rdy[k+1]);
            slc[k]   = {1'b0, a_in[k][k*S +: S]} + {1'b0, b_in[k][k*S +: S]} + (S+1)'(c_in[k]);
            nsum[k]  = s_in[k];
            nsum[k][k*S +: S] = slc[k][S-1:0];
            a_d[k]     = load[k] ? a_in[k]   : a_q[k];
            b_d[k]     = load[k] ? b_in[k]   : b_q[k];
            sum_d[k]   = load[k] ? nsum[k]   : sum_q[k];
            carry_d[k] = load[k] ? slc[k][S] : carry_q[k];
        end

        // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
        cout_n = slc[STAGES-1][S];
        ovf_n  = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
               ^ nsum[STAGES-1][WIDTH-1] ^ cout_n;
`ifdef ADD_PIPE_SAT_EN
        y_n = sat_fn(nsum[STAGES-1], ovf_n, a_in[STAGES-1][WIDTH-1]);
`else
        y_n = nsum[STAGES-1];
`endif
        y_d    = load[STAGES-1] ? y_n    : y_q;
        cout_d = load[STAGES-1] ? cout_n : cout_q;
        ovf_d  = load[STAGES-1] ? ovf_n  : ovf_q;
    end

    // Control and presented outputs: cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '{default: 1'b0};
            y_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            y_q    <= y_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    // Intermediate datapath: qualified by the stage valids, so no reset needed.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
    end

    assign bus.in_ready  = !rst && rdy[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.y         = y_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: 32b/4-stage main instance plus 32b/1-stage and 64b/8-stage sweeps.
module tb_add_pipe;
`ifdef ADD_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [63:0] y;
        logic        c;
        logic        o;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_pipe_if #(.WIDTH(32)) bus0();
    add_pipe_if #(.WIDTH(32)) bus1();
    add_pipe_if #(.WIDTH(64)) bus2();

    add_pipe #(.WIDTH(32), .STAGES(4)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    add_pipe #(.WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    add_pipe #(.WIDTH(64), .STAGES(8)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endfunction

    function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                      input logic s, output logic [63:0] y,
                                      output logic c, output logic o);
        logic [64:0] full;
        logic [63:0] mask, bb;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        bb   = (s ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + 65'(s);
        y    = full[63:0] & mask;
        c    = full[w];
        o    = (a[w-1] == bb[w-1]) && (y[w-1] != a[w-1]);
        if (SAT && o) y = a[w-1] ? (64'd1 << (w - 1)) : (mask >> 1);
    endfunction

    // Monitors: compare every output transfer against the head of the matching queue.
    always @(negedge clk) begin
        #1;
        if (!rst && bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL u0_extra_beat: got y=%0h, required no beat", bus0.y);
            end else begin
                e0 = q0.pop_front();
                chk("u0_y", 64'(bus0.y), e0.y);
                chk("u0_cout", 64'(bus0.cout), 64'(e0.c));
                chk("u0_ovf", 64'(bus0.ovf), 64'(e0.o));
                if (e0.lat) chk("u0_latency", 64'(cyc - e0.acc_cyc), 64'd4);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL u1_extra_beat: got y=%0h, required no beat", bus1.y);
            end else begin
                e1 = q1.pop_front();
                chk("u1_y", 64'(bus1.y), e1.y);
                chk("u1_cout", 64'(bus1.cout), 64'(e1.c));
                chk("u1_ovf", 64'(bus1.ovf), 64'(e1.o));
                if (e1.lat) chk("u1_latency", 64'(cyc - e1.acc_cyc), 64'd1);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && bus2.out_valid && bus2.out_ready) begin
            if (q2.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL u2_extra_beat: got y=%0h, required no beat", bus2.y);
            end else begin
                e2 = q2.pop_front();
                chk("u2_y", bus2.y, e2.y);
                chk("u2_cout", 64'(bus2.cout), 64'(e2.c));
                chk("u2_ovf", 64'(bus2.ovf), 64'(e2.o));
                if (e2.lat) chk("u2_latency", 64'(cyc - e2.acc_cyc), 64'd8);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the beat is accepted.
    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] ey, input logic ec, input logic eo, input bit lat);
        exp_t e;
        bit   done;
        done = 0;
        bus0.in_valid = 1'b1;
        bus0.a = a;
        bus0.b = b;
        bus0.sub = s;
        for (int t = 0; t < 100 && !done; t++) begin
            #1;
            if (bus0.in_ready) begin
                e.y = 64'(ey); e.c = ec; e.o = eo; e.lat = lat; e.acc_cyc = cyc;
                q0.push_back(e);
                done = 1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL u0_accept_timeout: got no in_ready in 100 cycles, required acceptance");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (q0.size() + q1.size() + q2.size()) != 0; t++) @(negedge clk);
        chk("drain_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    task automatic sweep1(input int n);
        logic [63:0] ra, rb;
        logic        rs;
        exp_t        e;
        for (int i = 0; i < n; i++) begin
            ra = (i == 0) ? 64'hFFFF_FFFF : (i == 1) ? 64'h7FFF_FFFF : 64'($urandom);
            rb = (i < 2) ? 64'd1 : 64'($urandom);
            rs = (i < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            bus1.in_valid = 1'b1;
            bus1.a = ra[31:0];
            bus1.b = rb[31:0];
            bus1.sub = rs;
            ref_model(32, ra, rb, rs, e.y, e.c, e.o);
            e.lat = 1; e.acc_cyc = cyc;
            #1;
            chk("u1_in_ready", 64'(bus1.in_ready), 64'd1);
            if (bus1.in_ready) q1.push_back(e);
            @(negedge clk);
        end
        bus1.in_valid = 1'b0;
    endtask

    task automatic sweep2(input int n);
        logic [63:0] ra, rb;
        logic        rs;
        exp_t        e;
        for (int i = 0; i < n; i++) begin
            ra = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (i == 1) ? 64'h8000_0000_0000_0000
                                                    : {$urandom, $urandom};
            rb = (i < 2) ? 64'd1 : {$urandom, $urandom};
            rs = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            bus2.in_valid = 1'b1;
            bus2.a = ra;
            bus2.b = rb;
            bus2.sub = rs;
            ref_model(64, ra, rb, rs, e.y, e.c, e.o);
            e.lat = 1; e.acc_cyc = cyc;
            #1;
            chk("u2_in_ready", 64'(bus2.in_ready), 64'd1);
            if (bus2.in_ready) q2.push_back(e);
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus0.in_valid = 0; bus0.a = '0; bus0.b = '0; bus0.sub = 0; bus0.out_ready = 1;
        bus1.in_valid = 0; bus1.a = '0; bus1.b = '0; bus1.sub = 0; bus1.out_ready = 1;
        bus2.in_valid = 0; bus2.a = '0; bus2.b = '0; bus2.sub = 0; bus2.out_ready = 1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_y", 64'(bus0.y), 64'd0);
        chk("rst_cout", 64'(bus0.cout), 64'd0);
        chk("rst_ovf", 64'(bus0.ovf), 64'd0);
        chk("rst_in_ready", 64'(bus0.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus0.in_ready), 64'd1);
        @(negedge clk);

        // Basic adds, back to back.
        send0(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1);
        send0(32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1);
        bus0.in_valid = 1'b0;
        drain();

        // Full carry ripple and signed overflow on add; subtracts with and without borrow.
        send0(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1);
        send0(32'h7FFF_FFFF, 32'd1, 1'b0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1);
        send0(32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0, 1);
        send0(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        send0(32'h8000_0000, 32'd1, 1'b1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1);
        bus0.in_valid = 1'b0;
        drain();

        // Backpressure: consumer stalls for cycles 3..7 of a 10-beat stream.
        fork
            begin
                for (int i = 1; i <= 10; i++) send0(32'(i), 32'(100 * i), 1'b0, 32'(101 * i), 1'b0, 1'b0, 0);
                bus0.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    bus0.out_ready = !(c >= 3 && c <= 7);
                    #1;
                    if (c == 3) chk("bp_in_ready_filling", 64'(bus0.in_ready), 64'd1);
                    if (c >= 4 && c <= 7) begin
                        chk("bp_in_ready_full", 64'(bus0.in_ready), 64'd0);
                        chk("bp_out_valid_hold", 64'(bus0.out_valid), 64'd1);
                        chk("bp_y_hold", 64'(bus0.y), 64'd101);
                    end
                    @(negedge clk);
                end
            end
        join
        drain();

        // Reset with three beats in flight; the in-flight beats are discarded.
        bus0.out_ready = 1'b0;
        send0(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 0);
        send0(32'd11, 32'd21, 1'b0, 32'd32, 1'b0, 1'b0, 0);
        send0(32'd12, 32'd22, 1'b0, 32'd34, 1'b0, 1'b0, 0);
        bus0.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_pre_out_valid", 64'(bus0.out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("mid_y", 64'(bus0.y), 64'd0);
        chk("mid_cout", 64'(bus0.cout), 64'd0);
        chk("mid_ovf", 64'(bus0.ovf), 64'd0);
        chk("mid_in_ready", 64'(bus0.in_ready), 64'd0);
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        send0(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1);
        bus0.in_valid = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        // Parameter sweep against the reference model.
        sweep1(20);
        drain();
        sweep2(20);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
